// File: rtl/sram_arbiter_if.sv
// Per-requester request/response bundle for sram_arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface sram_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [3:0]  wmask;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;

  modport master (
    output valid, we, wmask, addr, wdata,
    input  ready, rsp_valid, rdata
  );

  modport slave (
    input  valid, we, wmask, addr, wdata,
    output ready, rsp_valid, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 1RW 512x32 SRAM macro.
// Define SRAM_ARB_CLEAR_EN to zero-fill DEPTH words after reset before serving traffic.
module sram_arbiter #(
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave a,
  sram_arbiter_if.slave b,
  output logic          init_done,
  output logic          ram_clk0,
  output logic          ram_csb0,
  output logic          ram_web0,
  output logic [3:0]    ram_wmask0,
  output logic [8:0]    ram_addr0,
  output logic [31:0]   ram_din0,
  input  logic [31:0]   ram_dout0
);

`ifdef SRAM_ARB_CLEAR_EN
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_e;
  localparam logic [8:0] CLR_LAST = 9'(DEPTH - 1);
  logic [8:0] clr_cnt_q, clr_cnt_d;
`else
  typedef enum logic [1:0] {ST_RESET, ST_RUN} state_e;
`endif

  state_e      state_q, state_d;
  logic        last_a_q;          // 1: most recent grant went to A
  logic        pend_q;
  logic        owner_b_q;
  logic        a_rsp_q, b_rsp_q;
  logic [31:0] a_rdata_q, b_rdata_q;

  logic        run;
  logic        grant_a, grant_b;
  logic        sel_we;
  logic [3:0]  sel_wmask;
  logic [8:0]  sel_addr;
  logic [31:0] sel_wdata;

  // ---------------------------------------------------------------------------
  // State sequencing
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
`ifdef SRAM_ARB_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    unique case (state_q)
`ifdef SRAM_ARB_CLEAR_EN
      ST_RESET: state_d = ST_CLEAR;
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 9'd1;
        if (clr_cnt_q == CLR_LAST) state_d = ST_RUN;
      end
`else
      ST_RESET: state_d = ST_RUN;
`endif
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant: on a tie the requester not served most recently wins
  // ---------------------------------------------------------------------------
  assign run     = (state_q == ST_RUN);
  assign grant_a = run && a.valid && (!b.valid || !last_a_q);
  assign grant_b = run && b.valid && !grant_a;

  assign a.ready = grant_a;
  assign b.ready = grant_b;

  assign sel_we    = grant_b ? b.we    : a.we;
  assign sel_wmask = grant_b ? b.wmask : a.wmask;
  assign sel_addr  = grant_b ? b.addr  : a.addr;
  assign sel_wdata = grant_b ? b.wdata : a.wdata;

  // ---------------------------------------------------------------------------
  // SRAM command, driven straight from the accepted request
  // ---------------------------------------------------------------------------
  assign ram_clk0 = clk;

  always_comb begin
    ram_csb0   = 1'b1;
    ram_web0   = 1'b1;
    ram_wmask0 = 4'b0000;
    ram_addr0  = 9'd0;
    ram_din0   = 32'd0;
    if (grant_a || grant_b) begin
      ram_csb0   = 1'b0;
      ram_web0   = !sel_we;
      ram_wmask0 = sel_we ? sel_wmask : 4'b0000;
      ram_addr0  = sel_addr;
      ram_din0   = sel_wdata;
    end
`ifdef SRAM_ARB_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_csb0   = 1'b0;
      ram_web0   = 1'b0;
      ram_wmask0 = 4'b1111;
      ram_addr0  = clr_cnt_q;
      ram_din0   = 32'd0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers: state, grant history, read-response pipeline
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      last_a_q  <= 1'b0;
      pend_q    <= 1'b0;
      owner_b_q <= 1'b0;
      a_rsp_q   <= 1'b0;
      b_rsp_q   <= 1'b0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
`ifdef SRAM_ARB_CLEAR_EN
      clr_cnt_q <= 9'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SRAM_ARB_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
      if (grant_a || grant_b) last_a_q <= grant_a;
      pend_q    <= (grant_a || grant_b) && !sel_we;
      owner_b_q <= grant_b;
      // Macro output is valid one cycle after the accept edge; capture it here.
      a_rsp_q   <= pend_q && !owner_b_q;
      b_rsp_q   <= pend_q && owner_b_q;
      if (pend_q && !owner_b_q) a_rdata_q <= ram_dout0;
      if (pend_q && owner_b_q)  b_rdata_q <= ram_dout0;
    end
  end

  assign a.rsp_valid = a_rsp_q;
  assign b.rsp_valid = b_rsp_q;
  assign a.rdata     = a_rdata_q;
  assign b.rdata     = b_rdata_q;
  assign init_done   = run;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer for the single-port 1RW 32-bit SRAM macro (512 words, byte write mask). It sits between two on-chip requesters (A, B) and the macro's `ram_*` pins, granting at most one access per cycle and returning read data with fixed latency. It can optionally zero-fill the SRAM after reset before accepting traffic.

## Interface
- `DEPTH`, default 512: words covered by the clear sequence, 1..512.
- `clk` in 1: single clock; also drives `ram_clk0`.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid`, `b_valid` in 1: request valid.
- `a_ready`, `b_ready` out 1: request accepted this cycle.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_wmask`, `b_wmask` in 4: byte write mask, bit i enables byte i.
- `a_addr`, `b_addr` in 9: word address.
- `a_wdata`, `b_wdata` in 32: write data.
- `a_rsp_valid`, `b_rsp_valid` out 1: one-cycle read-response strobe.
- `a_rdata`, `b_rdata` out 32: registered read data.
- `init_done` out 1: high in RUN state.
- `ram_clk0` out 1: equal to `clk`.
- `ram_csb0` out 1: chip select, active low.
- `ram_web0` out 1: write enable, active low.
- `ram_wmask0` out 4: write mask.
- `ram_addr0` out 9: word address.
- `ram_din0` out 32: write data.
- `ram_dout0` in 32: macro read data, valid in the cycle after the capturing edge.

## Operation
- States:
  - RESET (reset value): exits at the first rising edge after `rst` falls, going to CLEAR if the macro is enabled, otherwise to RUN.
  - CLEAR: described under Configuration.
  - RUN: serves requests.
- Grant, RUN only:
  - Only one requester valid: grant it.
  - Both valid: grant the one not granted most recently. The last-grant register resets to B, so A wins the first tie.
  - Last-grant updates only on an accepted request.
- `x_ready` is high for the granted requester only and is combinational from the valids and state. A transfer occurs on the edge where `x_valid && x_ready`.
- A requester holding `x_valid` with `!x_ready` must keep its command stable.
- SRAM command is combinational from the granted request during the accept cycle:
  - `ram_csb0`=0, `ram_web0`=`!x_we`, `ram_addr0`=`x_addr`, `ram_din0`=`x_wdata`.
  - `ram_wmask0`=`x_wmask` for writes, 4'b0000 for reads.
- Idle (no grant, or RESET): `ram_csb0`=1, `ram_web0`=1, `ram_wmask0`=0, `ram_addr0`=0, `ram_din0`=0.
- Writes produce no response. A write with `wmask`=0 is still issued (no-op in the macro).
- Reads: a pending-response flag and owner are registered at the accept edge E. At edge E+1, `ram_dout0` is captured into the owner's `x_rdata` and `x_rsp_valid` pulses for exactly one cycle.
- `x_rdata` holds its value until the next response to the same owner.
- Reset values of all outputs:
  - `a_ready`/`b_ready` 0, `a_rsp_valid`/`b_rsp_valid` 0, `a_rdata`/`b_rdata` 0, `init_done` 0.
  - `ram_*` at idle values.

## Timing
- Throughput: one access per cycle, back-to-back, any mix of A/B and read/write.
- Read latency: accept edge E → `x_rsp_valid` high in the cycle after E+1 (2 edges).
- Read-after-write to the same address on consecutive edges returns the new data, per macro behaviour.
- Responses never collide: at most one read per edge, so at most one strobe per cycle.
- A new read accepted at edge E+1 overlaps the response capture of a read accepted at E; both are honoured.
- `rst` asserted mid-operation:
  - The in-flight response is dropped (no strobe).
  - Grant history returns to B.
  - Any clear sequence restarts from address 0 after release.
- No accept in RESET or CLEAR, even if valids are high; valids may be held across the transition.

## Configuration
- Macro `SRAM_ARB_CLEAR_EN`.
- Defined:
  - RESET→CLEAR at the first edge; the word counter starts at 0.
  - During CLEAR cycle k (k = 0..DEPTH-1) the block drives `ram_csb0`=0, `ram_web0`=0, `ram_wmask0`=4'b1111, `ram_addr0`=k, `ram_din0`=0.
  - On the edge capturing k=DEPTH-1 the state goes to RUN.
  - `init_done` rises after edge DEPTH+1.
  - Both readys are held 0 throughout CLEAR.
- Undefined:
  - No CLEAR state and no counter logic.
  - RESET→RUN at the first edge; `init_done` rises after edge 1.
  - SRAM contents after reset are undefined.

## Test plan
- Clear (macro on, DEPTH=8): release `rst` with `a_valid` high → 8 consecutive zero writes to addresses 0..7 with mask 4'hF; `a_ready`=0 until `init_done`=1 after edge 9; reading addr 5 then returns 0.
- Single port: A writes 0xDEADBEEF mask 4'hF to addr 0x1A5, then reads it → `a_rsp_valid` pulses once, 2 edges after the read accept, `a_rdata`=0xDEADBEEF; `b_rsp_valid` stays 0.
- Byte mask: write 0x11223344 to addr 3, then 0xAABBCCDD with mask 4'b0101 → read returns 0x11BB33DD.
- Contention: A and B both hold reads every cycle → grants alternate A,B,A,B starting with A; responses alternate owners with correct data each cycle at full throughput.
- Reset mid-read: assert `rst` the cycle after a read accept → no `rsp_valid` strobe; all outputs at reset values; after release the first tie grants A.
- Macro off: `init_done`=1 after the first edge post-reset; the first request is accepted in that cycle.
